seq_mult_acc: RTL and testbench

//  Parametrised shift-add sequential multiplier with signed/unsigned mode and optional accumulation.

---
 rtl/mac_pkg.sv | 18 +
 rtl/seq_mult_core.sv | 54 +++++
 rtl/seq_mult_acc.sv | 134 +++++++++++++
 tb/tb_seq_mult_acc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the bit-serial MAC datapath.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int PROD_W    = 2 * DEF_WIDTH;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Unsigned shift-add datapath: retires one multiplier bit per enabled cycle.
module seq_mult_core
    import mac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               en,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               done,
    output logic [2*WIDTH-1:0] pp_out
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [2*WIDTH:0] pp;
    logic [2*WIDTH:0] pp_add;
    logic [CW-1:0]    cnt;

    // Top bit of pp is the carry out of the upper-half add.
    always_comb begin
        pp_add = pp;
        if (mplier[0]) begin
            pp_add[2*WIDTH:WIDTH] = pp[2*WIDTH:WIDTH] + {1'b0, mcand};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            pp     <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            pp     <= '0;
            cnt    <= '0;
        end else if (en && !done) begin
            pp     <= pp_add >> 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign done   = (cnt == CW'(WIDTH));
    assign pp_out = pp[2*WIDTH-1:0];

endmodule

// File: rtl/seq_mult_acc.sv
// Sequential signed/unsigned multiplier with optional running accumulator.
module seq_mult_acc
    import mac_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = 2 * WIDTH + 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 acc_en,
    input  logic                 clr_acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 overflow,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int AM = ACC_WIDTH - 1;

    state_t               state;
    state_t               state_nx;
    logic                 neg_q;
    logic                 sm_q;
    logic                 acc_en_q;
    logic                 start;
    logic                 finish;
    logic                 take;
    logic                 done;
    logic                 do_acc;
    logic                 add_ovf;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [PW-1:0]        pp;
    logic [PW-1:0]        prod_nx;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] sum;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign start    = in_valid && in_ready;
    assign finish   = (state == CALC) && done;
    assign take     = (state == DONE) && out_ready;
    assign do_acc   = finish && acc_en_q;

    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign a_mag   = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign prod_nx = neg_q ? -pp : pp;

    seq_mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .en        (state == CALC),
        .mcand_in  (a_mag),
        .mplier_in (b_mag),
        .done      (done),
        .pp_out    (pp)
    );

    always_comb begin
        ext = ACC_WIDTH'(prod_nx);
        if (sm_q) begin
            ext = ACC_WIDTH'($signed(prod_nx));
        end
        sum     = acc + ext;
        add_ovf = (acc[AM] == ext[AM]) && (sum[AM] != acc[AM]);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start)     state_nx = CALC;
            CALC:    if (done)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q     <= 1'b0;
            sm_q      <= 1'b0;
            acc_en_q  <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            if (start) begin
                neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                sm_q     <= signed_mode;
                acc_en_q <= acc_en;
            end
            if (finish) begin
                product   <= prod_nx;
                out_valid <= 1'b1;
            end else if (take) begin
                out_valid <= 1'b0;
            end
        end
    end

    // A clear on the same edge as an accumulate leaves just the new product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (clr_acc) begin
            acc      <= do_acc ? ext : '0;
            overflow <= 1'b0;
        end else if (do_acc) begin
            acc      <= sum;
            overflow <= overflow | add_ovf;
        end
    end

endmodule

// File: tb/tb_seq_mult_acc.sv
// Directed and randomized checks of seq_mult_acc against an arithmetic model.
module tb_seq_mult_acc;

    localparam int W  = 16;
    localparam int AW = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signed_mode;
    logic          acc_en;
    logic          clr_acc;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;
    logic [AW-1:0] acc;
    logic          overflow;
    logic          busy;

    int     errors = 0;
    int     checks = 0;
    longint m_acc  = 0;
    bit     m_ovf  = 0;

    localparam longint ACC_MAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (AW - 1));

    seq_mult_acc #(
        .WIDTH     (W),
        .ACC_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .acc_en      (acc_en),
        .clr_acc     (clr_acc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .acc         (acc),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] x,
                                             input logic [15:0] y,
                                             input bit sm);
        longint p;
        if (sm) p = longint'($signed(x)) * longint'($signed(y));
        else    p = longint'({48'b0, x}) * longint'({48'b0, y});
        return p[31:0];
    endfunction

    function automatic void ref_acc(input logic [31:0] p, input bit sm,
                                    input bit clr);
        longint e;
        longint s;
        logic [AW-1:0] t;
        e = sm ? longint'($signed(p)) : longint'({32'b0, p});
        if (clr) begin
            m_acc = e;
            m_ovf = 0;
        end else begin
            s = m_acc + e;
            if (s > ACC_MAX || s < ACC_MIN) begin
                m_ovf = 1;
                t = s[AW-1:0];
                s = longint'($signed(t));
            end
            m_acc = s;
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_acc"}, acc, m_acc[AW-1:0]);
        check({tag, "_ovf"}, overflow, m_ovf);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input bit sm, input bit ae, input bit clr_done,
                          output logic [31:0] pobs);
        logic [31:0] ep;
        int n;
        ep = ref_prod(ta, tb, sm);
        check("in_ready_pre", in_ready, 1);
        in_valid    = 1;
        a           = ta;
        b           = tb;
        signed_mode = sm;
        acc_en      = ae;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 0;
        a           = W'($urandom);
        b           = W'($urandom);
        signed_mode = 1'($urandom);
        acc_en      = 1'($urandom);
        check("busy", busy, 1);
        n = 0;
        while (!out_valid && n < 40) begin
            if (clr_done && n == W) clr_acc = 1;
            @(posedge clk);
            n++;
            @(negedge clk);
            clr_acc = 0;
        end
        check("latency", n, W + 1);
        if (ae) begin
            ref_acc(ep, sm, clr_done);
        end else if (clr_done) begin
            m_acc = 0;
            m_ovf = 0;
        end
        check("product", product, ep);
        check_model("op");
        pobs = product;
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
            check("out_valid_fall", out_valid, 0);
            check("in_ready_post", in_ready, 1);
        end
    endtask

    task automatic clr_pulse();
        clr_acc = 1;
        @(posedge clk);
        @(negedge clk);
        clr_acc = 0;
        m_acc   = 0;
        m_ovf   = 0;
        check_model("clr");
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] held;
        int k;
        rst         = 1;
        in_valid    = 0;
        a           = '0;
        b           = '0;
        signed_mode = 0;
        acc_en      = 0;
        clr_acc     = 0;
        out_ready   = 1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        check_model("rst");
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // Basic products and latency
        run_op(16'd3, 16'd5, 0, 0, 0, p);
        check("u3x5", p, 32'h0000000F);
        run_op(16'hFFFF, 16'hFFFF, 0, 0, 0, p);
        check("uffff", p, 32'hFFFE0001);
        run_op(16'h8000, 16'h8000, 1, 0, 0, p);
        check("s8000", p, 32'h40000000);
        run_op(16'hFFFD, 16'h0007, 1, 0, 0, p);
        check("sm3x7", p, 32'hFFFFFFEB);

        // Accumulate sequence and clears
        run_op(16'hFFFD, 16'd7, 1, 1, 0, p);
        run_op(16'd100, 16'd100, 1, 1, 0, p);
        run_op(16'hFFFF, 16'hFFFF, 1, 1, 0, p);
        check("acc9980", acc, 40'd9980);
        check("acc9980_ovf", overflow, 0);
        clr_pulse();
        run_op(16'd5, 16'd5, 1, 1, 0, p);
        run_op(16'd2, 16'd2, 1, 1, 1, p);
        check("clr_add", acc, 40'd4);

        // Consumer back-pressure
        out_ready = 0;
        run_op(16'h0012, 16'h0034, 0, 0, 0, p);
        held = ref_prod(16'h0012, 16'h0034, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1;
            a        = 16'h0101;
            b        = 16'h0202;
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_product", product, held);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_product", product, held);
        run_op(16'd7, 16'd9, 0, 0, 0, p);

        // Reset in the middle of a calculation
        run_op(16'd11, 16'd13, 0, 1, 0, p);
        in_valid    = 1;
        a           = 16'd21;
        b           = 16'd22;
        signed_mode = 0;
        acc_en      = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        m_acc = 0;
        m_ovf = 0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_product", product, 0);
        check_model("mid_rst");
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        run_op(16'hFF00, 16'h0003, 1, 1, 0, p);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(0, 7) == 0, p);
        end

        // Drive the accumulator across the signed limit
        clr_pulse();
        k = 0;
        while (!m_ovf && k < 600) begin
            run_op(16'h7FFF, 16'h7FFF, 1, 1, 0, p);
            k++;
        end
        check("wrap_seen", m_ovf, 1);
        check("wrap_neg", acc[AW-1], 1);
        check("wrap_ovf", overflow, 1);
        run_op(16'd1, 16'd1, 1, 1, 0, p);
        check("sticky_ovf", overflow, 1);
        run_op(16'd3, 16'd3, 0, 0, 0, p);
        check("sticky_ovf2", overflow, 1);
        clr_pulse();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
